// File: rtl/axis_phase_reduce_if.sv
// AXI-Stream bundle shared by the angle input and the reduced-phase output.
interface axis_phase_reduce_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_phase_reduce.sv
// Reduces a signed fixed-point angle modulo 2*pi into [-pi, pi), rescales it to the
// CORDIC phase format and reports the signed number of 2*pi wraps in the output TUSER MSBs.
module axis_phase_reduce #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned IN_FRAC  = 24,
  parameter int unsigned OUT_FRAC = 29,
  parameter int unsigned USER_W   = 4,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_phase_reduce_if.slave   s_axis,
  axis_phase_reduce_if.master  m_axis,
  output logic                 busy
);
  localparam int unsigned SHIFT   = OUT_FRAC - IN_FRAC;
  localparam int unsigned XW      = IN_W + SHIFT + 1;
  localparam int unsigned OUT_W   = OUT_FRAC + 3;
  localparam int unsigned TUSER_W = WRAP_W + USER_W;

  localparam real PI_R      = 3.14159265358979323846;
  localparam real PI_SCALED = PI_R * (2.0 ** OUT_FRAC);
  localparam real WRAPS_MAX = (2.0 ** (IN_W - IN_FRAC - 1)) / (2.0 * PI_R);
  // Arguments are already integral, so the real-to-integer cast cannot change them.
  localparam longint PI_INT     = longint'($floor(PI_SCALED + 0.5));
  localparam longint TWO_PI_INT = longint'($floor(2.0 * PI_SCALED + 0.5));

  localparam logic signed [XW-1:0] PI_X     = XW'(PI_INT);
  localparam logic signed [XW-1:0] NEG_PI_X = -PI_X;
  localparam logic signed [XW-1:0] TWO_PI_X = XW'(TWO_PI_INT);

  if (OUT_FRAC < IN_FRAC) begin : g_frac_err
    $error("axis_phase_reduce: OUT_FRAC must be >= IN_FRAC");
  end
  if (USER_W < 1) begin : g_user_err
    $error("axis_phase_reduce: USER_W must be >= 1");
  end
  // The worst-case wrap count plus one must fit in the signed wrap counter.
  if ((2.0 ** (WRAP_W - 1)) - 2.0 < WRAPS_MAX) begin : g_wrap_err
    $error("axis_phase_reduce: WRAP_W too small for the input range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_OUT
  } state_e;

  state_e                   state_q, state_d;
  logic signed [XW-1:0]     x_q, x_d;
  logic [WRAP_W-1:0]        k_q, k_d;
  logic [USER_W-1:0]        user_q, user_d;
  logic                     last_q, last_d;
  logic [OUT_W-1:0]         tdata_q, tdata_d;
  logic [TUSER_W-1:0]       tuser_q, tuser_d;
  logic                     tlast_q, tlast_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tready_q, tready_d;
  logic                     busy_q, busy_d;

  logic signed [XW-1:0]     x_in;
  logic                     s_fire;
  logic                     ge_pi;
  logic                     lt_neg_pi;

  // Guard bit above the shifted input keeps the +/- 2*pi step from overflowing.
  assign x_in      = XW'($signed(s_axis.tdata)) <<< SHIFT;
  assign s_fire    = s_axis.tvalid && tready_q;
  assign ge_pi     = (x_q >= PI_X);
  assign lt_neg_pi = (x_q < NEG_PI_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (s_fire) state_d = ST_REDUCE;
      ST_REDUCE: if (!ge_pi && !lt_neg_pi) state_d = ST_OUT;
      ST_OUT:    if (m_axis.tready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // One wrap decision per REDUCE cycle; the output beat is captured once x is in range.
  always_comb begin
    x_d      = x_q;
    k_d      = k_q;
    user_d   = user_q;
    last_d   = last_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tvalid_d = (state_d == ST_OUT);
    tready_d = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (s_fire) begin
          x_d    = x_in;
          k_d    = '0;
          user_d = s_axis.tuser;
          last_d = s_axis.tlast;
        end
      end
      ST_REDUCE: begin
        if (ge_pi) begin
          x_d = x_q - TWO_PI_X;
          k_d = k_q + WRAP_W'(1);
        end else if (lt_neg_pi) begin
          x_d = x_q + TWO_PI_X;
          k_d = k_q - WRAP_W'(1);
        end else begin
          tdata_d = x_q[OUT_W-1:0];
          tuser_d = {k_q, user_q};
          tlast_d = last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      k_q      <= '0;
      user_q   <= '0;
      last_q   <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      k_q      <= k_d;
      user_q   <= user_d;
      last_q   <= last_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tvalid = tvalid_q;
  assign busy          = busy_q;

endmodule
